pdecoder2to4_buf: RTL and testbench
===================================

PDECODER2TO4_BUF -- requirements
Module: pdecoder2to4_buf

Interface
REQ-001 SHALL provide parameter CNT_W, default 8: width of each per-line hit counter; used only when PDEC_HITCNT_EN is defined.
REQ-002 SHALL provide port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL provide port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL provide port in, input, 2: encoded line index, 00..11.
REQ-005 SHALL provide port in_en, input, 1: 1 = index is valid, decode it; 0 = "no line active", decode to 4'b0000.
REQ-006 SHALL provide port in_valid, input, 1: upstream offers {in, in_en} this cycle.
REQ-007 SHALL provide port in_ready, output, 1: block accepts the offered word this cycle.
REQ-008 SHALL provide port out, output, 4: one-hot decoded word at buffer head.
REQ-009 SHALL provide port out_valid, output, 1: out holds a valid word.
REQ-010 SHALL provide port out_ready, input, 1: downstream consumes the word at head this cycle.
REQ-011 SHALL provide port hit_cnt, output, 4*CNT_W, only when PDEC_HITCNT_EN is defined: counter for line k in bits [k*CNT_W +: CNT_W].

Function
REQ-012 SHALL accept a word (push) on a cycle where in_valid=1 and in_ready=1, and SHALL release a word (pop) on a cycle where out_valid=1 and out_ready=1.
REQ-013 SHALL decode at push: in_en=1 -> out bit [in] set, all other bits clear (00->0001, 01->0010, 10->0100, 11->1000); in_en=0 -> 0000.
REQ-014 SHALL store decoded words in a 2-entry FIFO with a registered head; out SHALL be driven only from storage, with no combinational path from in to out.
REQ-015 SHALL implement occupancy states EMPTY, ONE, FULL: EMPTY-push->ONE; ONE-push-only->FULL; ONE-pop-only->EMPTY; ONE-push+pop->ONE; FULL-pop->ONE; all other combinations hold state.
REQ-016 SHALL drive in_ready=1 in EMPTY and ONE and in_ready=0 in FULL; in FULL a simultaneous pop SHALL NOT allow a same-cycle push.
REQ-017 SHALL drive out_valid=1 in ONE and FULL and out_valid=0 in EMPTY.
REQ-018 SHALL present a word pushed into EMPTY on out, with out_valid=1, on the cycle after the push (latency 1).
REQ-019 SHALL deliver words in push order; ONE with push+pop SHALL replace the head with the new word on the next cycle.
REQ-020 SHALL hold out and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL drive out=4'b0000 whenever out_valid=0.
REQ-022 SHALL treat in and in_en as don't-care when in_valid=0 or in_ready=0.

Reset
REQ-023 SHALL, on a rising clk edge with rst=1, force state EMPTY, out=0000, out_valid=0, in_ready=1, and all hit_cnt fields to 0.
REQ-024 SHALL discard buffered words on reset mid-operation; a push or pop coincident with rst=1 SHALL have no effect.
REQ-025 SHALL accept the first push on the first cycle after rst deasserts.

Configuration
REQ-026 SHALL use macro PDEC_HITCNT_EN to include or exclude the hit counters.
REQ-027 SHALL, with PDEC_HITCNT_EN defined, increment hit_cnt line k by 1 on each pop whose word has bit k set, and SHALL saturate at 2^CNT_W-1.
REQ-028 SHALL, with PDEC_HITCNT_EN defined, not increment any counter when a 0000 word is popped.
REQ-029 SHALL, without PDEC_HITCNT_EN, omit the hit_cnt port and all counter logic; all other behaviour SHALL be identical.

Verification
REQ-030 SHALL pass reset: rst=1 for 2 cycles during traffic -> out=0000, out_valid=0, in_ready=1, hit_cnt=0.
REQ-031 SHALL pass decode sweep: out_ready=1, push in=00,01,10,11 with in_en=1, then in=10 with in_en=0 -> out sequence 0001,0010,0100,1000,0000, each one cycle after its push.
REQ-032 SHALL pass backpressure: out_ready=0, push 11 then 01 -> in_ready=0 after the second push, out held at 1000; third offer ignored; out_ready=1 -> 1000 then 0010.
REQ-033 SHALL pass full+pop: in FULL, in_valid=1 and out_ready=1 -> one pop, no push; in_ready=1 on the next cycle.
REQ-034 SHALL pass streaming: ONE state, push+pop every cycle for 10 cycles -> output order matches input order, no loss or duplication.
REQ-035 SHALL pass counter saturation (PDEC_HITCNT_EN, CNT_W=4): pop 20 words of 0001 -> hit_cnt line 0 = 15, other lines = 0.

Source files
------------

// File: rtl/pdecoder2to4_buf.sv
// pdecoder2to4_buf: 2-to-4 one-hot decoder with a 2-entry valid/ready output buffer.
// The decoded word is computed at push time and stored; out is always driven
// from the head register, never combinationally from in.
// Optional per-line hit counters are included when PDEC_HITCNT_EN is defined.
module pdecoder2to4_buf #(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         in,
  input  logic               in_en,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [3:0]         out,
  output logic               out_valid,
  input  logic               out_ready
`ifdef PDEC_HITCNT_EN
  ,
  output logic [4*CNT_W-1:0] hit_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t       state_reg, state_next;
  logic [3:0] head_reg, head_next;
  logic [3:0] tail_reg, tail_next;
  logic [3:0] dec_word;
  logic       push;
  logic       pop;

  // Decode the offered index; a disabled index decodes to the empty word.
  always_comb begin
    dec_word = 4'b0000;
    if (in_en) begin
      dec_word = 4'b0001 << in;
    end
  end

  // Handshake flags: full buffer refuses input even when a pop is happening.
  always_comb begin
    in_ready  = (state_reg != FULL);
    out_valid = (state_reg != EMPTY);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Occupancy next-state and storage moves. The head is cleared on the way to
  // EMPTY so out reads 0000 whenever out_valid is low.
  always_comb begin
    state_next = state_reg;
    head_next  = head_reg;
    tail_next  = tail_reg;
    unique case (state_reg)
      EMPTY: begin
        if (push) begin
          head_next  = dec_word;
          state_next = ONE;
        end
      end
      ONE: begin
        if (push && pop) begin
          head_next  = dec_word;
        end else if (push) begin
          tail_next  = dec_word;
          state_next = FULL;
        end else if (pop) begin
          head_next  = 4'b0000;
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          head_next  = tail_reg;
          state_next = ONE;
        end
      end
      default: begin
        head_next  = 4'b0000;
        state_next = EMPTY;
      end
    endcase
  end

  // State and storage registers; reset discards any buffered words.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      head_reg  <= 4'b0000;
      tail_reg  <= 4'b0000;
    end else begin
      state_reg <= state_next;
      head_reg  <= head_next;
      tail_reg  <= tail_next;
    end
  end

  assign out = head_reg;

`ifdef PDEC_HITCNT_EN
  logic [CNT_W-1:0] cnt_reg [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_hit
    // Count pops of words with this line set, saturating at all-ones.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_reg[gi] <= '0;
      end else if (pop && head_reg[gi] && (cnt_reg[gi] != {CNT_W{1'b1}})) begin
        cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
      end
    end
    assign hit_cnt[gi*CNT_W +: CNT_W] = cnt_reg[gi];
  end
`endif

endmodule

// File: tb/tb_pdecoder2to4_buf.sv
// Directed bench for pdecoder2to4_buf. Counter checks are compiled in only
// when PDEC_HITCNT_EN is defined (then CNT_W=4).
module tb_pdecoder2to4_buf;

  localparam int CNT_W = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] din;
  logic       din_en;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] dout;
  logic       out_valid;
  logic       out_ready;
`ifdef PDEC_HITCNT_EN
  logic [4*CNT_W-1:0] hit_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pdecoder2to4_buf #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (din),
    .in_en     (din_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (dout),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef PDEC_HITCNT_EN
    ,
    .hit_cnt   (hit_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      $display("check %-18s obs=%0h exp=%0h", tag, obs, exp);
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_w;

    // Reset with an offer pending
    rst = 1'b1; din = 2'd3; din_en = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    check("rst_out",       32'(dout),      32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready",  32'(in_ready),  32'h1);

    // Decode sweep, out_ready held high: each word appears one cycle after push
    out_ready = 1'b1; in_valid = 1'b1;
    din = 2'd0; din_en = 1'b1; tick();
    check("sweep_00", 32'(dout), 32'h1);
    check("sweep_00_v", 32'(out_valid), 32'h1);
    din = 2'd1; tick();
    check("sweep_01", 32'(dout), 32'h2);
    din = 2'd2; tick();
    check("sweep_10", 32'(dout), 32'h4);
    din = 2'd3; tick();
    check("sweep_11", 32'(dout), 32'h8);
    din = 2'd2; din_en = 1'b0; tick();
    check("sweep_dis", 32'(dout), 32'h0);
    check("sweep_dis_v", 32'(out_valid), 32'h1);
    in_valid = 1'b0; tick();
    check("sweep_drain_v", 32'(out_valid), 32'h0);
    check("sweep_drain_out", 32'(dout), 32'h0);
`ifdef PDEC_HITCNT_EN
    check("hit_after_sweep", 32'(hit_cnt), 32'h1111);
`endif

    // Backpressure: two pushes fill the buffer, third offer ignored
    out_ready = 1'b0; in_valid = 1'b1; din_en = 1'b1;
    din = 2'd3; tick();
    check("bp_first_out", 32'(dout), 32'h8);
    check("bp_first_rdy", 32'(in_ready), 32'h1);
    din = 2'd1; tick();
    check("bp_full_rdy", 32'(in_ready), 32'h0);
    check("bp_full_out", 32'(dout), 32'h8);
    din = 2'd0; tick();
    check("bp_hold_out", 32'(dout), 32'h8);
    check("bp_hold_v", 32'(out_valid), 32'h1);
    in_valid = 1'b0; out_ready = 1'b1; tick();
    check("bp_pop1_out", 32'(dout), 32'h2);
    check("bp_pop1_rdy", 32'(in_ready), 32'h1);
    tick();
    check("bp_pop2_v", 32'(out_valid), 32'h0);

    // FULL with offer and pop: only the pop happens
    out_ready = 1'b0; in_valid = 1'b1; din_en = 1'b1;
    din = 2'd0; tick();
    din = 2'd2; tick();
    check("fp_full_rdy", 32'(in_ready), 32'h0);
    din = 2'd3; out_ready = 1'b1; tick();
    check("fp_pop_out", 32'(dout), 32'h4);
    check("fp_pop_rdy", 32'(in_ready), 32'h1);
    in_valid = 1'b0; tick();
    check("fp_no_push", 32'(out_valid), 32'h0);

    // Streaming from ONE: push+pop each cycle, head follows input order
    out_ready = 1'b1; in_valid = 1'b1; din_en = 1'b1;
    din = 2'd0; tick();
    for (int k = 0; k < 10; k++) begin
      din = 2'((k + 1) % 4);
      exp_w = 4'b0001 << ((k + 1) % 4);
      tick();
      check($sformatf("stream_%0d", k), 32'(dout), 32'(exp_w));
    end
    check("stream_rdy", 32'(in_ready), 32'h1);
    in_valid = 1'b0; tick();
    check("stream_drain", 32'(out_valid), 32'h0);

    // Reset mid-operation with traffic, then immediate push
    out_ready = 1'b0; in_valid = 1'b1; din = 2'd1; tick(); tick();
    rst = 1'b1; out_ready = 1'b1; din = 2'd3; tick(); tick();
    check("mid_rst_out", 32'(dout), 32'h0);
    check("mid_rst_v", 32'(out_valid), 32'h0);
    check("mid_rst_rdy", 32'(in_ready), 32'h1);
`ifdef PDEC_HITCNT_EN
    check("mid_rst_hit", 32'(hit_cnt), 32'h0);
`endif
    rst = 1'b0; din = 2'd1; out_ready = 1'b0; tick();
    check("post_rst_push", 32'(dout), 32'h2);
    check("post_rst_v", 32'(out_valid), 32'h1);

`ifdef PDEC_HITCNT_EN
    // Saturation: 20 pops of 0001 after a fresh reset
    rst = 1'b1; in_valid = 1'b0; tick();
    rst = 1'b0; out_ready = 1'b1; in_valid = 1'b1; din = 2'd0; din_en = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    in_valid = 1'b0; tick();
    check("sat_line0", 32'(hit_cnt[0*CNT_W +: CNT_W]), 32'd15);
    check("sat_others", 32'(hit_cnt[4*CNT_W-1:CNT_W]), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
